// File: rtl/pw_pkg.sv
// Shared keypad password definitions.
// Key codes, digit width and the entry-state enum.
package pw_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [3:0] KEY_BKSP  = 4'hA;
  localparam logic [3:0] KEY_CLR   = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_MASK  = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    FULL
  } pw_state_e;

endpackage

// File: rtl/pw_timeout_timer.sv
// Idle timer: counts while i_en, cleared by i_clr or !i_en.
// Ports: i_clk, i_rst_n, i_clr, i_en, o_expire (comb pulse at TIMEOUT_CYCLES-1).
module pw_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             expire;

  always_comb begin
    expire = i_en && !i_clr && (cnt_q == LAST);
    if (i_clr || !i_en || expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = expire;

endmodule

// File: rtl/keypad_password_encoder.sv
// Keypad entry: builds a BCD password, commits it on Enter, auto-clears on idle.
// Ports: i_clk, i_rst_n, i_key_valid, i_key_code -> o_password, o_pw_valid,
//   o_live, o_disp_en, o_digit_cnt, o_error, o_timeout. Macro KEYPAD_PW_MASK_EN hides o_live digits.
module keypad_password_encoder
  import pw_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_key_valid,
  input  logic [3:0]                    i_key_code,
  output logic [DIGIT_W*NUM_DIGITS-1:0] o_password,
  output logic                          o_pw_valid,
  output logic [DIGIT_W*NUM_DIGITS-1:0] o_live,
  output logic                          o_disp_en,
  output logic [1:0]                    o_digit_cnt,
  output logic                          o_error,
  output logic                          o_timeout
);

  localparam int         PW_W     = DIGIT_W * NUM_DIGITS;
  localparam logic [1:0] FULL_CNT = 2'(NUM_DIGITS);

  pw_state_e        state_q, state_d;
  logic [PW_W-1:0]  buf_q, buf_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [PW_W-1:0]  pw_q, pw_d;
  logic [PW_W-1:0]  live_q, live_d;
  logic             pwv_q, pwv_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;
  logic             disp_q, disp_d;
  logic             expire;
  logic             is_digit;

  pw_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_key_valid),
    .i_en    (state_q != IDLE),
    .o_expire(expire)
  );

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    pw_d     = pw_q;
    pwv_d    = 1'b0;
    err_d    = 1'b0;
    tmo_d    = 1'b0;
    is_digit = (i_key_code <= 4'd9);
    if (i_key_valid) begin
      unique case (1'b1)
        is_digit: begin
          if (state_q == FULL) begin
            err_d = 1'b1;
          end else begin
            buf_d   = {buf_q[PW_W-DIGIT_W-1:0], i_key_code};
            cnt_d   = cnt_q + 2'd1;
            state_d = (cnt_q + 2'd1 == FULL_CNT) ? FULL : ENTRY;
          end
        end
        (i_key_code == KEY_BKSP): begin
          if (cnt_q != 2'd0) begin
            buf_d   = buf_q >> DIGIT_W;
            cnt_d   = cnt_q - 2'd1;
            state_d = (cnt_q == 2'd1) ? IDLE : ENTRY;
          end
        end
        (i_key_code == KEY_CLR): begin
          buf_d   = '0;
          cnt_d   = 2'd0;
          state_d = IDLE;
        end
        (i_key_code == KEY_ENTER): begin
          if (state_q == FULL) begin
            pw_d    = buf_q;
            pwv_d   = 1'b1;
            buf_d   = '0;
            cnt_d   = 2'd0;
            state_d = IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (expire) begin
      buf_d   = '0;
      cnt_d   = 2'd0;
      state_d = IDLE;
      tmo_d   = 1'b1;
    end
    disp_d = (state_d != IDLE);
`ifdef KEYPAD_PW_MASK_EN
    live_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i < int'(cnt_d)) begin
        live_d[i*DIGIT_W +: DIGIT_W] = KEY_MASK;
      end
    end
`else
    live_d = buf_d;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= 2'd0;
      pw_q    <= '0;
      live_q  <= '0;
      pwv_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      disp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
      live_q  <= live_d;
      pwv_q   <= pwv_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      disp_q  <= disp_d;
    end
  end

  assign o_password  = pw_q;
  assign o_pw_valid  = pwv_q;
  assign o_live      = live_q;
  assign o_disp_en   = disp_q;
  assign o_digit_cnt = cnt_q;
  assign o_error     = err_q;
  assign o_timeout   = tmo_q;

endmodule

// File: tb/tb_keypad_password_encoder.sv
// Bench for keypad_password_encoder: directed plan then random keys.
// Reference model keeps the entered digits in a queue.
module tb_keypad_password_encoder;

  localparam int T = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kv = 1'b0;
  logic [3:0]  kc = 4'h0;
  logic [11:0] o_password;
  logic        o_pw_valid;
  logic [11:0] o_live;
  logic        o_disp_en;
  logic [1:0]  o_digit_cnt;
  logic        o_error;
  logic        o_timeout;

  keypad_password_encoder #(
    .NUM_DIGITS    (3),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_key_valid(kv),
    .i_key_code (kc),
    .o_password (o_password),
    .o_pw_valid (o_pw_valid),
    .o_live     (o_live),
    .o_disp_en  (o_disp_en),
    .o_digit_cnt(o_digit_cnt),
    .o_error    (o_error),
    .o_timeout  (o_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

`ifdef KEYPAD_PW_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  int          q[$];
  logic [11:0] m_pw;
  int          idle;
  bit          m_pwv, m_err, m_tmo;

  function automatic logic [11:0] pack(input bit mask);
    logic [11:0] v;
    v = '0;
    foreach (q[i]) v = {v[7:0], mask ? 4'hF : 4'(q[i])};
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pw = '0;
    idle = 0;
    m_pwv = 0;
    m_err = 0;
    m_tmo = 0;
  endtask

  task automatic model_step(input bit v, input logic [3:0] c);
    m_pwv = 0;
    m_err = 0;
    m_tmo = 0;
    if (v) begin
      idle = 0;
      if (c <= 4'd9) begin
        if (q.size() == 3) m_err = 1;
        else q.push_back(int'(c));
      end else if (c == 4'hA) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (c == 4'hB) begin
        q.delete();
      end else if (c == 4'hE) begin
        if (q.size() == 3) begin
          m_pw = pack(1'b0);
          m_pwv = 1;
          q.delete();
        end else begin
          m_err = 1;
        end
      end
    end else if (q.size() > 0) begin
      if (idle == T - 1) begin
        q.delete();
        m_tmo = 1;
        idle = 0;
      end else begin
        idle++;
      end
    end else begin
      idle = 0;
    end
  endtask

  task automatic check_all();
    chk("live", o_live, pack(MASK));
    chk("password", o_password, m_pw);
    chk("pw_valid", o_pw_valid, m_pwv);
    chk("error", o_error, m_err);
    chk("timeout", o_timeout, m_tmo);
    chk("digit_cnt", o_digit_cnt, q.size());
    chk("disp_en", o_disp_en, q.size() > 0);
  endtask

  task automatic step(input bit v, input logic [3:0] c);
    kv = v;
    kc = c;
    @(posedge clk);
    model_step(v, c);
    #1;
    kv = 1'b0;
    kc = 4'h0;
    check_all();
  endtask

  task automatic key(input logic [3:0] c);
    step(1'b1, c);
  endtask

  task automatic idle_n(input int n);
    repeat (n) step(1'b0, 4'h0);
  endtask

  int lat;

  initial begin
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    key(4'h1); key(4'h2); key(4'h3);
    chk("full_cnt", o_digit_cnt, 3);
    key(4'hE);
    chk("pw123", o_password, 12'h123);
    chk("pwv123", o_pw_valid, 1);
    idle_n(1);

    key(4'h4); key(4'h5); key(4'hE);
    chk("err_short", o_error, 1);
    key(4'h6); key(4'hE);
    chk("pw456", o_password, 12'h456);

    key(4'h7); key(4'h8); key(4'h9); key(4'h0);
    chk("err_4th", o_error, 1);
    key(4'hA);
    chk("bksp_cnt", o_digit_cnt, 2);
    key(4'hC); key(4'hD); key(4'hF);
    key(4'hB);
    key(4'hA);

    key(4'h5);
    lat = 0;
    for (int k = 1; k <= T + 2; k++) begin
      step(1'b0, 4'h0);
      if (o_timeout && lat == 0) lat = k;
    end
    chk("tmo_latency", lat, T);
    key(4'h5);
    idle_n(T - 1);
    key(4'h6);
    chk("tmo_key_wins", o_timeout, 0);
    chk("tmo_key_cnt", o_digit_cnt, 2);
    key(4'hB);

    key(4'h1); key(4'h2);
`ifdef KEYPAD_PW_MASK_EN
    chk("live12", o_live, 12'h0FF);
`else
    chk("live12", o_live, 12'h012);
`endif
    key(4'h3); key(4'hE);
    chk("pw123b", o_password, 12'h123);

    key(4'h3); key(4'h4);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 15) begin
        idle_n(int'($urandom_range(1, 13)));
      end else if (r < 70) begin
        key(4'($urandom_range(0, 9)));
      end else if (r < 80) begin
        key(4'hA);
      end else if (r < 85) begin
        key(4'hB);
      end else if (r < 97) begin
        key(4'hE);
      end else begin
        case ($urandom_range(0, 2))
          0: key(4'hC);
          1: key(4'hD);
          default: key(4'hF);
        endcase
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
